// File: rtl/pcie_cfg_arb_pkg.sv
// Shared types and helpers for the configuration-space access arbiter.
package pcie_cfg_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitRd,
    StResp
  } cfg_state_e;

  // Wide enough for any supported DATA_W; users slice the low DATA_W bits.
  localparam logic [255:0] CFG_ERR_DATA = '1;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pcie_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i.
module pcie_rr_arbiter
  import pcie_cfg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr_i) + i) % NUM_REQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/pcie_cfg_arbiter.sv
// Round-robin sharing of the endpoint config port; one access in flight at a time.
// Read timeout is compiled in only when PCIE_CFG_ARB_TIMEOUT_EN is defined.
module pcie_cfg_arbiter
  import pcie_cfg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         ccfg_addr,
  output logic [DATA_W-1:0]         ccfg_wdata,
  output logic                      ccfg_write,
  output logic                      ccfg_read,
  input  logic [DATA_W-1:0]         ccfg_rdata,
  input  logic                      ccfg_rvalid,
  output logic                      busy
);

  localparam int unsigned IdxW = idx_width(NUM_REQ);
  localparam logic [DATA_W-1:0] ErrData = CFG_ERR_DATA[DATA_W-1:0];
  localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYC out of range");
  end

  cfg_state_e          state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic                wr_q, wr_d;
  logic                misal_q, misal_d;
  logic [ADDR_W-1:0]   ccfg_addr_q, ccfg_addr_d;
  logic [DATA_W-1:0]   ccfg_wdata_q, ccfg_wdata_d;
  logic                ccfg_write_q, ccfg_write_d;
  logic                ccfg_read_q, ccfg_read_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
`ifdef PCIE_CFG_ARB_TIMEOUT_EN
  logic [7:0]          cnt_q, cnt_d;
`endif

  logic [NUM_REQ-1:0]  gnt;
  logic [IdxW-1:0]     gnt_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_write;
  logic                accept;

  pcie_rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IdxW)
  ) u_rr_arbiter (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx)
  );

  assign req_ready = (rst_n && state_q == StIdle) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign sel_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
  assign sel_write = req_write[gnt_idx];

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    misal_d      = misal_q;
    ccfg_addr_d  = ccfg_addr_q;
    ccfg_wdata_d = ccfg_wdata_q;
    ccfg_write_d = 1'b0;
    ccfg_read_d  = 1'b0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
`ifdef PCIE_CFG_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StIssue;
          owner_d = gnt_idx;
          wr_d    = sel_write;
          misal_d = (sel_addr[1:0] != 2'b00);
          // Strobes are registered here so they are high during the ISSUE cycle.
          if (sel_addr[1:0] == 2'b00) begin
            ccfg_addr_d  = sel_addr;
            ccfg_wdata_d = sel_wdata;
            ccfg_write_d = sel_write;
            ccfg_read_d  = !sel_write;
          end
        end
      end
      StIssue: begin
        if (misal_q) begin
          state_d     = StResp;
          rsp_valid_d = OneHot0 << owner_q;
          rsp_rdata_d = ErrData;
          rsp_err_d   = 1'b1;
        end else if (wr_q) begin
          state_d     = StResp;
          rsp_valid_d = OneHot0 << owner_q;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end else begin
          state_d = StWaitRd;
`ifdef PCIE_CFG_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StWaitRd: begin
        if (ccfg_rvalid) begin
          state_d     = StResp;
          rsp_valid_d = OneHot0 << owner_q;
          rsp_rdata_d = ccfg_rdata;
          rsp_err_d   = 1'b0;
`ifdef PCIE_CFG_ARB_TIMEOUT_EN
        end else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          state_d     = StResp;
          rsp_valid_d = OneHot0 << owner_q;
          rsp_rdata_d = ErrData;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
`endif
        end
      end
      StResp: begin
        state_d  = StIdle;
        rr_ptr_d = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      wr_q         <= 1'b0;
      misal_q      <= 1'b0;
      ccfg_addr_q  <= '0;
      ccfg_wdata_q <= '0;
      ccfg_write_q <= 1'b0;
      ccfg_read_q  <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
`ifdef PCIE_CFG_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      misal_q      <= misal_d;
      ccfg_addr_q  <= ccfg_addr_d;
      ccfg_wdata_q <= ccfg_wdata_d;
      ccfg_write_q <= ccfg_write_d;
      ccfg_read_q  <= ccfg_read_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
`ifdef PCIE_CFG_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign ccfg_addr  = ccfg_addr_q;
  assign ccfg_wdata = ccfg_wdata_q;
  assign ccfg_write = ccfg_write_q;
  assign ccfg_read  = ccfg_read_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: doc/pcie_cfg_arbiter.md
# pcie_cfg_arbiter

Sequences and shares the endpoint configuration-space access port (`ccfg_*`) among several requesters, such as the host TLP config decoder, the local management CPU and the BAR-side mailbox. It arbitrates round-robin and issues exactly one access at a time. It tracks each read until data returns or a timeout fires, then returns a completion to the granted requester. It sits directly in front of the `pcie_endpoint` configuration port.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ADDR_W`, default 6: config address width.
- `DATA_W`, default 32: config data width.
- `TIMEOUT_CYC`, default 16: maximum WAIT_RD cycles before an error completion, 1..255.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester request accept, one-hot or zero.
- `req_write`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_W  packed addresses; requester i uses slice i.
- `req_wdata`  in  NUM_REQ*DATA_W  packed write data.
- `rsp_valid`  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- `rsp_rdata`  out  DATA_W  shared completion data, valid with `rsp_valid`.
- `rsp_err`  out  1  completion error flag, valid with `rsp_valid`.
- `ccfg_addr`  out  ADDR_W  downstream address.
- `ccfg_wdata`  out  DATA_W  downstream write data.
- `ccfg_write`  out  1  downstream write strobe, one cycle.
- `ccfg_read`  out  1  downstream read strobe, one cycle.
- `ccfg_rdata`  in  DATA_W  downstream read data.
- `ccfg_rvalid`  in  1  downstream read data valid.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE → ISSUE → (WAIT_RD) → RESP → IDLE.
- **IDLE**
  - The round-robin arbiter picks the first asserted `req_valid` at or after pointer `rr_ptr`.
  - `req_ready[winner]` = 1, combinationally, in this state only.
  - On `valid && ready`, latch write flag, address, data and the winner index, then go to ISSUE.
- **ISSUE**
  - If `addr[1:0] != 0`: no downstream strobe; go to RESP with `err = 1` and `rdata = {DATA_W{1'b1}}`.
  - Otherwise drive `ccfg_addr` and `ccfg_wdata`, and pulse `ccfg_write` or `ccfg_read` for one cycle.
  - Writes go to RESP with `err = 0` and `rdata = 0`. Reads go to WAIT_RD.
- **WAIT_RD**
  - On `ccfg_rvalid`: capture `ccfg_rdata` and go to RESP with `err = 0`.
  - A counter increments each WAIT_RD cycle. If it reaches `TIMEOUT_CYC` with no `rvalid`, go to RESP with `err = 1` and `rdata = {DATA_W{1'b1}}`.
- **RESP**
  - Pulse `rsp_valid[owner]` with the registered `rsp_rdata` and `rsp_err`.
  - Set `rr_ptr = (owner + 1) mod NUM_REQ`, then return to IDLE.
- `ccfg_rvalid` is ignored outside WAIT_RD. Late data after a timeout is dropped.
- Requesters hold `valid` and payload stable until accepted. A requester that is not granted keeps waiting with no starvation; the worst-case wait is NUM_REQ−1 transactions.
- Reset during any state returns to IDLE with `rr_ptr = 0`. An in-flight transaction produces no completion.
- Reset values: `req_ready` = 0 (forced while `rst_n` = 0), `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, all `ccfg_*` outputs = 0, `busy` = 0.

## Timing
- Request accepted at cycle T.
- The `ccfg` strobe is high in cycle T+1.
- Write or misaligned access: `rsp_valid` in cycle T+2.
- Read: WAIT_RD begins in T+2. If `ccfg_rvalid` is seen in cycle T+1+k (k ≥ 1), `rsp_valid` is in T+2+k. The minimum read latency is 3.
- Timeout: `rsp_valid` in cycle T+2+TIMEOUT_CYC.
- Next acceptance is at the earliest one cycle after RESP. Throughput is at most one write per 3 cycles.

## Configuration
- `PCIE_CFG_ARB_TIMEOUT_EN`
  - Defined: the WAIT_RD timeout counter and the error completion are compiled in.
  - Undefined: no counter. WAIT_RD waits indefinitely for `ccfg_rvalid`, and `rsp_err` is only set by misaligned addresses.

## Structure
- Package `pcie_cfg_arb_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT_RD, RESP);
  - the constant `CFG_ERR_DATA = '1`;
  - the width function for the index, `$clog2(NUM_REQ)`.
- Sub-module `pcie_rr_arbiter`: a parameterised combinational round-robin picker. Inputs are the `req` vector and `rr_ptr`; outputs are the one-hot grant and the grant index.

## Test plan
- **Single write.** Requester 1 writes addr 0x08, data 0xDEADBEEF. Expect `ccfg_write` = 1 at T+1 with addr 0x08 and data 0xDEADBEEF. Expect `rsp_valid[1]` at T+2 with `err` = 0.
- **Read with delay.** Requester 0 reads 0x04. `ccfg_rvalid` returns 0x00100007 three cycles after the strobe. Expect `rsp_valid[0]` with that data and `err` = 0 at T+5.
- **Round-robin fairness.** All four requesters hold continuous writes. Expect grant order 0, 1, 2, 3, 0 and no requester granted twice before the others.
- **Read timeout** (macro on, TIMEOUT_CYC = 16). Never assert `rvalid`. Expect the `rsp_valid` pulse at T+18 with `err` = 1 and data 0xFFFFFFFF. A later `rvalid` produces no response.
- **Misaligned address.** Read of addr 0x05. Expect no `ccfg_read` and a completion at T+2 with `err` = 1 and data 0xFFFFFFFF.
- **Reset mid-read.** Assert `rst_n` = 0 in WAIT_RD. Expect all outputs 0 and no completion. The next grant after reset goes to requester 0.
